// File: rtl/prom_pkg.sv
// Constants and types shared by the PROM reader, the PROM writer and the AXI PROM slave.
package prom_pkg;

   localparam int PROM_ADDR_W     = 15;
   localparam int PROM_BANK_BYTES = 4096;
   localparam int PROM_BYTES      = 5 * PROM_BANK_BYTES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } prom_rd_state_t;

   // True when a 4-byte word starting at addr lies entirely inside the populated PROM.
   function automatic logic prom_word_in_range(input logic [PROM_ADDR_W-1:0] addr);
      return ({{(32-PROM_ADDR_W){1'b0}}, addr} <= 32'(PROM_BYTES - 4));
   endfunction

endpackage

// File: rtl/prom_word_reader.sv
// Word reader on the PROM's byte-wide read port: four sequential byte reads, little-endian
// assembly, range-checked so no access is made beyond the last populated byte.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ISSUE | byte read k=0..3 on the PROM port, capturing the byte of read k-1
// DRAIN | capturing the byte of the last read into lane 3
// RESP  | holding the response until the consumer takes it
module prom_word_reader
   import prom_pkg::*;
#(
   parameter int ADDR_W    = PROM_ADDR_W,
   parameter int MEM_BYTES = PROM_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_din
);

   localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

   prom_rd_state_t    state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       lane_q, lane_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic              mem_en_q, mem_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              accept;
   logic              out_of_range;

   assign req_ready    = (state_q == IDLE);
   assign accept       = req_valid && req_ready;
   assign out_of_range = ({{(32-ADDR_W){1'b0}}, req_addr} > LAST_WORD_ADDR);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      resp_err_d = resp_err_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d = req_addr;
               cnt_d  = 2'd0;
               lane_d = '0;
               if (out_of_range) begin
                  resp_err_d = 1'b1;
                  state_d    = RESP;
               end else begin
                  resp_err_d = 1'b0;
                  state_d    = ISSUE;
               end
            end
         end
         ISSUE: begin
            // mem_din lags the issue by one cycle, so this cycle holds the byte of read k-1.
            if (cnt_q != 2'd0) begin
               lane_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem_din;
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            lane_d[31:24] = mem_din;
            state_d       = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are precomputed from the next state so they leave the block registered.
      resp_valid_d = (state_d == RESP);
      mem_en_d     = (state_d == ISSUE);
      mem_addr_d   = mem_en_d ? (addr_d + ADDR_W'(cnt_d)) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= '0;
         lane_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         lane_q       <= lane_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         mem_en_q     <= mem_en_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = lane_q;
   assign resp_err   = resp_err_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = 1'b0;
   assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_prom_word_reader.sv
// Bench for prom_word_reader: byte-array PROM model, scoreboard of expected words and
// expected PROM accesses, directed boundary cases followed by randomized traffic.
module tb_prom_word_reader;

   localparam int AW        = 15;
   localparam int MEM_BYTES = 20480;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b1;
   logic [31:0]   resp_data;
   logic          resp_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;

   prom_word_reader #(.ADDR_W(AW), .MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            acc;
      logic [AW-1:0] addr;
      logic          err;
      logic [31:0]   data;
   } exp_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
   } mop_t;

   logic [7:0] mem [MEM_BYTES];
   exp_t       exp_q[$];
   mop_t       mop_q[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         rr_mode = 0;
   int         last_hs = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // PROM read port: data one cycle after the enable, garbage otherwise.
   always @(posedge clk) begin
      if (mem_en && (int'(mem_addr) < MEM_BYTES)) mem_din <= mem[int'(mem_addr)];
      else mem_din <= 8'($urandom);
   end

   always @(posedge clk) begin
      #1;
      if (rr_mode == 1) resp_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
   endtask

   // Behavioural reference: word = four PROM bytes, little-endian, or error past the end.
   function automatic exp_t model(input int acc, input logic [AW-1:0] a);
      exp_t e;
      int   ai;
      ai     = int'(a);
      e.acc  = acc;
      e.addr = a;
      if (ai + 4 > MEM_BYTES) begin
         e.err  = 1'b1;
         e.data = 32'h0;
      end else begin
         e.err  = 1'b0;
         e.data = {mem[ai+3], mem[ai+2], mem[ai+1], mem[ai]};
      end
      return e;
   endfunction

   // Monitor and scoreboard.
   logic        chk_rst = 1'b0;
   logic        prev_v = 1'b0, prev_r = 1'b0, prev_e = 1'b0;
   logic [31:0] prev_d = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mop_q.delete();
         chk_rst = 1'b1;
         prev_v  = 1'b0;
         prev_r  = 1'b0;
      end else begin
         if (chk_rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_err", 64'(resp_err), 64'd0);
            chk("rst_resp_data", 64'(resp_data), 64'd0);
            chk("rst_mem_en", 64'(mem_en), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk_rst = 1'b0;
         end
         chk("mem_we", 64'(mem_we), 64'd0);
         if (mem_en === 1'b1) begin
            if (mop_q.size() == 0) begin
               fail_now("mem_en_unexpected");
            end else begin
               mop_t m;
               m = mop_q.pop_front();
               chk("mem_cycle", 64'(cyc), 64'(m.cyc));
               chk("mem_addr", 64'(mem_addr), 64'(m.addr));
            end
         end else begin
            chk("mem_addr_idle", 64'(mem_addr), 64'd0);
            if (mop_q.size() != 0 && mop_q[0].cyc <= cyc) begin
               fail_now("mem_en_missing");
               void'(mop_q.pop_front());
            end
         end
         if (resp_valid && req_ready) fail_now("req_ready_while_resp");
         if (resp_valid && !prev_v) begin
            if (exp_q.size() == 0) fail_now("resp_spurious");
            else chk("resp_latency", 64'(cyc - exp_q[0].acc), exp_q[0].err ? 64'd1 : 64'd6);
         end
         if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", 64'(resp_data), 64'(prev_d));
            chk("hold_err", 64'(resp_err), 64'(prev_e));
         end
         if (resp_valid && resp_ready) begin
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               fail_now("resp_no_request");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("resp_data", 64'(resp_data), 64'(e.data));
               chk("resp_err", 64'(resp_err), 64'(e.err));
            end
         end
         if (req_valid && req_ready) begin
            exp_t e;
            e = model(cyc, req_addr);
            exp_q.push_back(e);
            if (!e.err) begin
               for (int k = 0; k < 4; k++) begin
                  mop_t m;
                  m.cyc  = cyc + 1 + k;
                  m.addr = AW'(int'(req_addr) + k);
                  mop_q.push_back(m);
               end
            end
         end
         prev_v = resp_valid;
         prev_r = resp_ready;
         prev_d = resp_data;
         prev_e = resp_err;
      end
   end

   // Driver. All input changes happen 1 time unit after the rising edge.
   task automatic wait_accept(output int acc);
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = cyc;
            return;
         end
      end
      $display("FAIL accept_timeout: request at %0h never accepted", req_addr);
      total++;
      bad++;
   endtask

   task automatic issue(input logic [AW-1:0] a, output int acc);
      req_valid = 1'b1;
      req_addr  = a;
      wait_accept(acc);
      @(posedge clk) #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk) #1;
         if (exp_q.size() == 0 && req_ready) return;
      end
      fail_now("drain_timeout");
   endtask

   int acc_a, acc_b, hs_cyc;
   int a_rand;

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
      mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
      mem[16'h0FFE] = 8'hAA; mem[16'h0FFF] = 8'hBB; mem[16'h1000] = 8'hCC; mem[16'h1001] = 8'hDD;
      mem[16'h4FFC] = 8'h5A; mem[16'h4FFD] = 8'h6B; mem[16'h4FFE] = 8'h7C; mem[16'h4FFF] = 8'h8D;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk) #1;

      // Directed words: basic, bank crossing, last word, just past the end, top of address space.
      issue(15'h0100, acc_a); drain();
      chk("word_0100", 64'(resp_data), 64'h44332211);
      issue(15'h0FFE, acc_a); drain();
      chk("word_0FFE", 64'(resp_data), 64'hDDCCBBAA);
      issue(15'h4FFC, acc_a); drain();
      chk("word_4FFC", 64'(resp_data), 64'h8D7C6B5A);
      issue(15'h4FFD, acc_a); drain();
      issue(15'h7FFF, acc_a); drain();

      // Backpressure with a second request waiting.
      rr_mode    = 2;
      resp_ready = 1'b0;
      issue(15'h0100, acc_a);
      req_valid = 1'b1;
      req_addr  = 15'h0200;
      for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
      if (!resp_valid) fail_now("bp_no_resp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      end
      @(posedge clk) #1;
      resp_ready = 1'b1;
      hs_cyc     = cyc;
      wait_accept(acc_b);
      chk("bp_accept_cycle", 64'(acc_b), 64'(hs_cyc + 1));
      @(posedge clk) #1;
      req_valid = 1'b0;
      drain();
      rr_mode = 0;

      // Reset three cycles into a read, then the same read again.
      issue(15'h0100, acc_a);
      @(posedge clk) #1;
      @(posedge clk) #1;
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      issue(15'h0100, acc_a); drain();
      chk("word_after_rst", 64'(resp_data), 64'h44332211);

      // Back-to-back with req_valid held.
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 15'h0000;
      wait_accept(acc_a);
      @(posedge clk) #1;
      req_addr = 15'h0004;
      wait_accept(acc_b);
      @(posedge clk) #1;
      req_valid = 1'b0;
      chk("b2b_spacing", 64'(acc_b - acc_a), 64'd7);
      drain();

      // Random traffic with random consumer stalls.
      rr_mode = 1;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) a_rand = int'($urandom_range(MEM_BYTES - 3, 32767));
         else a_rand = int'($urandom_range(0, MEM_BYTES - 4));
         issue(AW'(a_rand), acc_a);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      rr_mode    = 0;
      resp_ready = 1'b1;
      drain();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("mem_ops_empty", 64'(mop_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
